// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit.
//   state_e   : controller state encoding (IDLE, SHIFT, TRIAL, DONE)
//   cnt_width : bits needed to hold the iteration count WIDTH/2
package sqrt_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StTrial = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/sqrt_ctrl.sv
// Sequencer for sqrt_iter_n: FSM plus iteration counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   init_i        : start request, honoured only in IDLE
//   ld_o          : load operand and clear R/Q (IDLE accepting init)
//   sh_o          : shift two radicand bits into R (SHIFT)
//   trial_en_o    : perform trial subtraction and root-bit update (TRIAL)
//   ld_res_o      : capture result registers (last TRIAL)
//   busy_o        : high in SHIFT and TRIAL
//   done_o        : high in DONE
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_i,
  output logic ld_o,
  output logic sh_o,
  output logic trial_en_o,
  output logic ld_res_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CntW = cnt_width(Width);
  localparam logic [CntW-1:0] CntInit = CntW'(Width / 2);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_o       = 1'b0;
    sh_o       = 1'b0;
    trial_en_o = 1'b0;
    ld_res_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_i) begin
          ld_o    = 1'b1;
          cnt_d   = CntInit;
          state_d = StShift;
        end
      end
      StShift: begin
        sh_o    = 1'b1;
        state_d = StTrial;
      end
      StTrial: begin
        trial_en_o = 1'b1;
        cnt_d      = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          ld_res_o = 1'b1;
          state_d  = StDone;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        // Holding init keeps us here so one long request yields one operation.
        if (!init_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q == StShift) || (state_q == StTrial);
  assign done_o = (state_q == StDone);

endmodule

// File: rtl/sqrt_iter_n.sv
// Iterative restoring integer square root, two radicand bits per iteration.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   init_i        : start request (level), accepted only when idle
//   radicand_i    : WIDTH-bit operand, sampled on the accepting edge
//   root_o        : floor(sqrt(radicand)), held until the next result
//   remainder_o   : radicand - root^2, held until the next result
//   busy_o        : computation in progress
//   done_o        : result ready; cleared once init_i is seen low
module sqrt_iter_n
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_i,
  input  logic [WIDTH-1:0]   radicand_i,
  output logic [WIDTH/2-1:0] root_o,
  output logic [WIDTH/2:0]   remainder_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned Half = WIDTH / 2;
  // One extra bit beyond the remainder range carries the trial sign.
  localparam int unsigned RW   = Half + 2;

  logic             ld, sh, trial_en, ld_res;
  logic [WIDTH-1:0] a_q, a_d;
  logic [RW-1:0]    r_q, r_d, trial;
  logic [Half-1:0]  q_q, q_d, root_q, root_d;
  logic [Half:0]    rem_q, rem_d;

  sqrt_ctrl #(
    .Width (WIDTH)
  ) u_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .init_i     (init_i),
    .ld_o       (ld),
    .sh_o       (sh),
    .trial_en_o (trial_en),
    .ld_res_o   (ld_res),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  assign trial = r_q - {q_q, 2'b01};

  always_comb begin
    a_d    = a_q;
    r_d    = r_q;
    q_d    = q_q;
    root_d = root_q;
    rem_d  = rem_q;
    if (ld) begin
      a_d = radicand_i;
      r_d = '0;
      q_d = '0;
    end
    if (sh) begin
      r_d = {r_q[Half-1:0], a_q[WIDTH-1 -: 2]};
      a_d = {a_q[WIDTH-3:0], 2'b00};
    end
    if (trial_en) begin
      // Negative trial (MSB set) restores: R keeps its value, root bit is 0.
      if (!trial[RW-1]) r_d = trial;
      q_d = {q_q[Half-2:0], ~trial[RW-1]};
    end
    if (ld_res) begin
      root_d = q_d;
      rem_d  = r_d[Half:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else begin
      a_q    <= a_d;
      r_q    <= r_d;
      q_q    <= q_d;
      root_q <= root_d;
      rem_q  <= rem_d;
    end
  end

  assign root_o      = root_q;
  assign remainder_o = rem_q;

endmodule

// File: doc/sqrt_iter_n.md
# sqrt_iter_n

- Parametrised iterative integer square-root unit: FSM and datapath in one block.
- Computes floor(sqrt(radicand)) and the remainder for any even WIDTH.
- Uses the restoring digit-by-digit method: two radicand bits per iteration.
- Sits in the calculator's arithmetic core beside the other multi-cycle operators. The operator sequencer starts it with init/done.
- New behaviour: generic width, a busy flag, a remainder output, result registers that hold until the next operation, and a restartable done handshake instead of a terminal state.

## Interface
- WIDTH, 16: radicand width. Must be even and ≥ 4.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init  input  1  start request, level-sampled. Accepted only in IDLE.
- radicand  input  WIDTH  operand, sampled on the edge that accepts init.
- root  output  WIDTH/2  registered result, floor(sqrt(radicand)).
- remainder  output  WIDTH/2+1  registered result, radicand − root².
- busy  output  1  high in SHIFT and TRIAL.
- done  output  1  high in DONE.

## Operation
- Internal registers:
  - A (WIDTH): shifting radicand.
  - R (WIDTH/2+2): partial remainder.
  - Q (WIDTH/2): partial root.
  - cnt: ceil(log2(WIDTH/2+1)) bits.
  - res_root, res_rem: output registers.
- FSM states: IDLE, SHIFT, TRIAL, DONE.
- IDLE:
  - On init=1: A←radicand, R←0, Q←0, cnt←WIDTH/2, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - R←{R[WIDTH/2−1:0], A[WIDTH−1:WIDTH−2]}, A←A<<2, go to TRIAL.
- TRIAL:
  - T = R − {Q, 2'b01}, computed at WIDTH/2+2 bits.
  - If T's MSB is 0: R←T and Q←{Q[WIDTH/2−2:0],1}.
  - If T's MSB is 1: R is unchanged and Q←{Q[WIDTH/2−2:0],0}.
  - cnt←cnt−1.
  - If cnt==1: load res_root←next Q and res_rem←next R[WIDTH/2:0], then go to DONE. Otherwise go to SHIFT.
- DONE:
  - done=1.
  - If init=0, go to IDLE.
  - If init=1, stay in DONE. The requester must drop init before a new start is accepted, so one held init never yields two operations.
- init while busy or in DONE is ignored. radicand changes after the accepting edge are ignored.
- root/remainder change only on the edge that enters DONE. They keep the last result through IDLE and the next computation.
- Width rules:
  - The maximum remainder is 2·root, so it always fits WIDTH/2+1 bits.
  - The top bit of R is only the sign of the trial subtraction.
  - No overflow or saturation is possible.
- Radicand 0 and radicand 2^WIDTH−1 take the same path and latency as any other operand. There is no early exit.

## Timing
- Reset values: state=IDLE, all internal registers 0, root=0, remainder=0, busy=0, done=0.
- rst_n low mid-operation:
  - Aborts immediately and asynchronously.
  - All outputs go to reset values.
  - The operation is lost, with no partial result.
  - After rst_n deasserts, the first edge sees IDLE.
- Latency:
  - Call the edge that samples init=1 in IDLE edge 0.
  - busy=1 from after edge 0 through edge WIDTH.
  - done=1 and valid root/remainder from after edge WIDTH.
  - Example: 17 cycles for WIDTH=16.
- Throughput: one operation per WIDTH+2 cycles minimum, since init must be seen low for one cycle in DONE.
- busy and done are decoded from state: Moore outputs, glitch-free relative to clk, never both high.

## Structure
- Shared package sqrt_pkg holds:
  - State encoding localparams: IDLE, SHIFT, TRIAL, DONE.
  - A function computing cnt width from WIDTH.
- One sub-module is natural: sqrt_ctrl.
  - Contains the FSM and cnt.
  - Inputs: init, trial sign, cnt==1.
  - Outputs: ld, sh, trial_en, ld_res, busy, done.
- The top level holds the A/R/Q datapath and result registers.

## Test plan
- WIDTH=16, radicand=144, one-cycle init pulse -> done after 17 edges; root=12, remainder=0; busy high exactly 16 cycles.
- WIDTH=16, radicand=143 -> root=11, remainder=22. Then radicand=0 -> root=0, remainder=0.
- WIDTH=16, radicand=65535 -> root=255, remainder=510, using the full remainder width.
- WIDTH=8, radicand=200 -> root=14, remainder=4 after 9 edges. Sweep all 256 values against a reference model.
- init held high for 40 cycles with radicand=144 -> exactly one operation; done stays high until init drops, then IDLE. Toggling init and radicand while busy does not change the result.
- rst_n pulsed low at cycle 5 of an operation -> busy, done, root, remainder all 0 immediately. A subsequent init with radicand=81 -> root=9, remainder=0.
